// File: rtl/burst_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : burst_cmd_sequencer
// Description : Splits FIFO transfer commands into AXI-legal bursts, issues
//               them one at a time and returns one merged status per command.
// Revision    : 1.0 - initial release
// ============================================================================
module burst_cmd_sequencer #(
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 16,
    parameter int ID_W       = 4,
    parameter int DATA_BYTES = 8,
    parameter int MAX_BEATS  = 16,
    parameter int CMD_W      = ID_W + 1 + ADDR_W + LEN_W,
    parameter int RESP_W     = ID_W + 3
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    cmd_fifo_empty,
    output logic                                    cmd_pop_req,
    input  logic                                    cmd_pop_ack,
    input  logic [CMD_W-1:0]                        cmd_pop_struct,
    input  logic                                    resp_fifo_full,
    output logic                                    resp_push_req,
    input  logic                                    resp_push_ack,
    output logic [RESP_W-1:0]                       resp_push_struct,
    output logic                                    bst_start,
    output logic                                    bst_wr,
    output logic [ADDR_W-1:0]                       bst_addr,
    output logic [$clog2(MAX_BEATS*DATA_BYTES):0]   bst_bytes,
    output logic [$clog2(MAX_BEATS):0]              bst_beats,
    input  logic                                    bst_done,
    input  logic [1:0]                              bst_resp,
    output logic                                    busy,
    output logic [15:0]                             cmd_done_cnt
);

    localparam int BYTES_W = $clog2(MAX_BEATS*DATA_BYTES) + 1;
    localparam int BEATS_W = $clog2(MAX_BEATS) + 1;
    localparam int CW0     = (LEN_W > 13) ? LEN_W : 13;
    localparam int CW      = ((CW0 > BYTES_W) ? CW0 : BYTES_W) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_POP   = 3'd1;
    localparam logic [2:0] S_CALC  = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_PUSH  = 3'd5;
    localparam logic [2:0] S_GAP   = 3'd6;

    logic [2:0]         r_state;
    logic [2:0]         w_next;

    logic [ID_W-1:0]    r_id;
    logic               r_wr;
    logic [ADDR_W-1:0]  r_cur_addr;
    logic [LEN_W-1:0]   r_rem;
    logic [1:0]         r_status;
    logic [ADDR_W-1:0]  r_bst_addr;
    logic [BYTES_W-1:0] r_bst_bytes;
    logic [BEATS_W-1:0] r_bst_beats;
    logic [15:0]        r_cnt;

    logic [ID_W-1:0]    w_cmd_id;
    logic               w_cmd_wr;
    logic [ADDR_W-1:0]  w_cmd_addr;
    logic [LEN_W-1:0]   w_cmd_len;
    logic [CW-1:0]      w_off;
    logic [CW-1:0]      w_to4k;
    logic [CW-1:0]      w_maxb;
    logic [CW-1:0]      w_rem;
    logic [CW-1:0]      w_min1;
    logic [CW-1:0]      w_chunk;
    logic [CW-1:0]      w_beats;
    logic [LEN_W-1:0]   w_rem_after;
    logic               w_unused_full;

    // Response FIFO fullness is informational; the push handshake already waits on ack.
    assign w_unused_full = resp_fifo_full;

    assign w_cmd_len  = cmd_pop_struct[LEN_W-1:0];
    assign w_cmd_addr = cmd_pop_struct[LEN_W +: ADDR_W];
    assign w_cmd_wr   = cmd_pop_struct[LEN_W+ADDR_W];
    assign w_cmd_id   = cmd_pop_struct[CMD_W-1 -: ID_W];

    // Burst size is the tightest of remaining length, 4 KB page end and MAX_BEATS window.
    assign w_off   = CW'(r_cur_addr & ADDR_W'(DATA_BYTES - 1));
    assign w_to4k  = CW'(13'd4096 - {1'b0, r_cur_addr[11:0]});
    assign w_maxb  = CW'(MAX_BEATS * DATA_BYTES) - w_off;
    assign w_rem   = CW'(r_rem);
    assign w_min1  = (w_rem < w_to4k) ? w_rem : w_to4k;
    assign w_chunk = (w_min1 < w_maxb) ? w_min1 : w_maxb;
    assign w_beats = (w_off + w_chunk + CW'(DATA_BYTES - 1)) / CW'(DATA_BYTES);

    assign w_rem_after = r_rem - LEN_W'(r_bst_bytes);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (!cmd_fifo_empty) w_next = S_POP;
            S_POP:   if (cmd_pop_ack) w_next = (w_cmd_len == '0) ? S_PUSH : S_CALC;
            S_CALC:  w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (bst_done) w_next = (w_rem_after != '0) ? S_CALC : S_PUSH;
            S_PUSH:  if (resp_push_ack) w_next = S_GAP;
            S_GAP:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_pop_req   = 1'b0;
        resp_push_req = 1'b0;
        bst_start     = 1'b0;
        busy          = 1'b1;
        case (r_state)
            S_IDLE:  busy          = 1'b0;
            S_POP:   cmd_pop_req   = 1'b1;
            S_ISSUE: bst_start     = 1'b1;
            S_PUSH:  resp_push_req = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_id        <= '0;
            r_wr        <= 1'b0;
            r_cur_addr  <= '0;
            r_rem       <= '0;
            r_status    <= 2'd0;
            r_bst_addr  <= '0;
            r_bst_bytes <= '0;
            r_bst_beats <= '0;
            r_cnt       <= 16'd0;
        end else begin
            case (r_state)
                S_POP: begin
                    if (cmd_pop_ack) begin
                        r_id       <= w_cmd_id;
                        r_wr       <= w_cmd_wr;
                        r_cur_addr <= w_cmd_addr;
                        r_rem      <= w_cmd_len;
                        r_status   <= 2'd0;
                    end
                end
                S_CALC: begin
                    r_bst_addr  <= r_cur_addr;
                    r_bst_bytes <= BYTES_W'(w_chunk);
                    r_bst_beats <= BEATS_W'(w_beats);
                end
                S_WAIT: begin
                    if (bst_done) begin
                        if (bst_resp > r_status) r_status <= bst_resp;
                        r_cur_addr <= r_cur_addr + ADDR_W'(r_bst_bytes);
                        r_rem      <= w_rem_after;
                    end
                end
                S_PUSH: begin
                    if (resp_push_ack) r_cnt <= r_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign resp_push_struct = {r_id, r_wr, r_status};
    assign bst_wr           = r_wr;
    assign bst_addr         = r_bst_addr;
    assign bst_bytes        = r_bst_bytes;
    assign bst_beats        = r_bst_beats;
    assign cmd_done_cnt     = r_cnt;

endmodule
`default_nettype wire

// File: doc/burst_cmd_sequencer.md
Name: burst_cmd_sequencer

Overview:
- Pulls transfer commands from the command FIFO on its PL-side pop port and splits each one into AXI-legal bursts for the burst engine.
- Splitting handles misaligned start addresses, the MAX_BEATS limit and 4 KB boundaries.
- Issues the bursts to the burst engine one at a time, collects each burst's response and pushes one merged status per command into the response FIFO.
- Sits between the CPU/PL command/response FIFO pair and the burst engine; it is the only PL-side agent on those FIFOs.

Parameters:
ADDR_W, 32, byte address width
LEN_W, 16, command length field width (bytes)
ID_W, 4, command tag width
DATA_BYTES, 8, data bus width in bytes (power of 2)
MAX_BEATS, 16, max beats per burst (power of 2, ≤256)
CMD_W, ID_W+1+ADDR_W+LEN_W, command struct width: {id, wr, addr, len}
RESP_W, ID_W+3, response struct width: {id, wr, status[1:0]}

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cmd_fifo_empty  in  1  command FIFO empty
cmd_pop_req  out  1  pop request; held high until ack
cmd_pop_ack  in  1  pop acknowledge; struct valid this cycle
cmd_pop_struct  in  CMD_W  popped command
resp_fifo_full  in  1  response FIFO full (status only)
resp_push_req  out  1  push request; held high until ack
resp_push_ack  in  1  push acknowledge
resp_push_struct  out  RESP_W  response; stable while resp_push_req is high
bst_start  out  1  one-cycle burst launch pulse
bst_wr  out  1  1=write, 0=read
bst_addr  out  ADDR_W  unaligned start address of burst
bst_bytes  out  $clog2(MAX_BEATS*DATA_BYTES)+1  payload bytes in burst
bst_beats  out  $clog2(MAX_BEATS)+1  beat count (AXI LEN = beats-1)
bst_done  in  1  one-cycle burst completion pulse
bst_resp  in  2  AXI response for completed burst, valid with bst_done
busy  out  1  high in any state except IDLE
cmd_done_cnt  out  16  commands completed; wraps at 0xFFFF

Behaviour:
- Reset (async, active-high): FSM=IDLE. All outputs 0, including cmd_done_cnt. Internal registers cleared. An in-flight burst is abandoned; bst_done after reset while IDLE is ignored.
- FSM states: IDLE, POP, CALC, ISSUE, WAIT, PUSH, GAP.
- IDLE: when cmd_fifo_empty=0, go to POP and raise cmd_pop_req the next cycle.
- POP: hold cmd_pop_req=1. On cmd_pop_ack, latch id/wr/addr/len into cur_addr and remaining, set status_acc=0, drop req the next cycle.
  - len==0 goes to PUSH with status OKAY; no burst is issued.
  - Otherwise go to CALC.
- CALC (1 cycle):
  - off = cur_addr mod DATA_BYTES
  - to4k = 4096 − cur_addr[11:0]
  - maxb = MAX_BEATS*DATA_BYTES − off
  - chunk = min(remaining, to4k, maxb)
  - beats = ceil((off+chunk)/DATA_BYTES)
  - Register bst_addr=cur_addr, bst_bytes=chunk, bst_beats=beats. Go to ISSUE.
- ISSUE: bst_start=1 for exactly one cycle. bst_* outputs are held stable from CALC until bst_done. Go to WAIT.
- WAIT: on bst_done:
  - status_acc = max(status_acc, bst_resp).
  - cur_addr += chunk; remaining −= chunk (full-width, no truncation).
  - remaining>0 goes to CALC; otherwise go to PUSH.
  - An error response does not abort; all bursts of the command are still issued.
- PUSH: resp_push_struct = {id, wr, status_acc}; hold resp_push_req=1 until resp_push_ack. When resp_fifo_full=1, resp_push_req stays high and the acknowledge arrives once space exists. On ack, cmd_done_cnt += 1 and go to GAP.
- GAP: all reqs low for one cycle, which guarantees a fresh rising edge for the next request. Then go to IDLE.
- Latency, idle to first bst_start with an ack k cycles after req: 1 (IDLE→POP) + k + 1 (CALC) + 1.
- Only one burst is outstanding at a time. bst_done outside WAIT is ignored.
- cmd_pop_req and resp_push_req are never high simultaneously. The FSM never re-raises a req without at least one low cycle in between.
- Address arithmetic wraps modulo 2^ADDR_W. Commands are not permitted to wrap past the top of the address space (behaviour is undefined in that case, not checked).

Test Plan:
- Aligned write, addr=0x1000, len=64 (DATA_BYTES=8, MAX_BEATS=16) -> one bst_start with addr 0x1000, bytes 64, beats 8. Response {id, 1, 0}; cmd_done_cnt=1.
- Misaligned read, addr=0x1003, len=10 -> one burst with bytes 10, beats 2 (off 3+10=13). Response status OKAY.
- 4 KB crossing, addr=0x0FF8, len=32 -> burst (0x0FF8, 8 bytes, 1 beat) then (0x1000, 24 bytes, 3 beats), in order.
- Oversize with error, addr=0x2000, len=300; bst_resp 0,2,0 -> bursts of 128/16, 128/16 and 44/6 (bytes/beats), all three issued. Response status=2 (SLVERR).
- Back-pressure and zero length: resp_fifo_full=1 with ack delayed 20 cycles -> resp_push_req held high, struct stable, no new pop until ack. A following len=0 command produces no bst_start and a response with status 0.
- Reset asserted in WAIT mid-command -> all outputs 0 in the same cycle (asynchronously). A late bst_done is ignored; the next command is processed normally.
